// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: per-pin input synchroniser and interrupt scheduler.
// Raw pads pass through a SYNC_STAGES-deep synchroniser and appear as padin_o.
// Level and edge events on enabled input pins latch into a sticky status
// register. Reading that register clears it. irq_o is the OR of the status bits.
module gpio_irq_ctrl #(
   parameter int GPIO_NUM    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [GPIO_NUM-1:0] gpio_in_i,
   input  logic [GPIO_NUM-1:0] dir_i,
   input  logic [GPIO_NUM-1:0] inten_i,
   input  logic [GPIO_NUM-1:0] inttype0_i,
   input  logic [GPIO_NUM-1:0] inttype1_i,
   input  logic                stat_rd_i,
   output logic [GPIO_NUM-1:0] padin_o,
   output logic [GPIO_NUM-1:0] status_o,
   output logic                irq_o
);

   // The arm counter must be able to hold SYNC_STAGES+1.
   localparam int              CNT_W   = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0] ARM_VAL = CNT_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][GPIO_NUM-1:0] sync_q, sync_d;
   logic [GPIO_NUM-1:0]                  prev_q, prev_d;
   logic [GPIO_NUM-1:0]                  status_q, status_d;
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic                                 irq_q, irq_d;

   logic [GPIO_NUM-1:0]                  padin;
   logic [GPIO_NUM-1:0]                  cond;
   logic [GPIO_NUM-1:0]                  evt;
   logic                                 armed;

   assign padin = sync_q[SYNC_STAGES-1];

   // After reset the zeroed chain fills with pad values. That fill looks like
   // rising edges, so events stay blocked until the chain and prev hold real samples.
   assign armed = (cnt_q == ARM_VAL);

   // Shift the synchroniser chain one stage per clock.
   always_comb begin
      sync_d[0] = gpio_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   // prev follows padin every cycle, whatever the configuration.
   // Enabling an interrupt on a static pin therefore never produces an edge.
   always_comb begin
      prev_d = padin;
   end

   // Count up through the arm window, then hold.
   always_comb begin
      cnt_d = armed ? cnt_q : cnt_q + CNT_W'(1);
   end

   // Per-pin event condition selected by {inttype1, inttype0}:
   // 00 level high, 01 level low, 10 rising edge, 11 falling edge.
   genvar gi;
   generate
      for (gi = 0; gi < GPIO_NUM; gi++) begin : g_pin
         assign cond[gi] = inttype1_i[gi]
                         ? (inttype0_i[gi] ? (~padin[gi] &  prev_q[gi])
                                           : ( padin[gi] & ~prev_q[gi]))
                         : (inttype0_i[gi] ? ~padin[gi] : padin[gi]);
         assign evt[gi]  = cond[gi] & inten_i[gi] & ~dir_i[gi] & armed;
      end
   endgenerate

   // Sticky status with clear-on-read. A new event wins over a clear in the same
   // cycle. irq is computed from the next value so it moves together with status.
   always_comb begin
      status_d = (stat_rd_i ? '0 : status_q) | evt;
      irq_d    = |status_d;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync_q   <= '0;
         prev_q   <= '0;
         status_q <= '0;
         cnt_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         prev_q   <= prev_d;
         status_q <= status_d;
         cnt_q    <= cnt_d;
         irq_q    <= irq_d;
      end
   end

   assign padin_o  = padin;
   assign status_o = status_q;
   assign irq_o    = irq_q;

endmodule
